// File: rtl/bcast_fork.sv
// rtl/bcast_fork.sv - one-to-many broadcast fork holding one word until every destined channel has taken it.
// Optional BCAST_FORK_MASK_EN adds a per-word dst_mask selecting which channels receive the word.
module bcast_fork #(
  parameter int OUT  = 4,
  parameter int DATA = 16
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA-1:0]          in_data,
`ifdef BCAST_FORK_MASK_EN
  input  logic [OUT-1:0]           dst_mask,
`endif
  output logic [OUT-1:0]           out_valid,
  input  logic [OUT-1:0]           out_ready,
  output logic [OUT-1:0][DATA-1:0] out_data,
  output logic                     busy
);

  logic [OUT-1:0]  pend_q, pend_d;
  logic [OUT-1:0]  fire;
  logic [OUT-1:0]  dest;
  logic [DATA-1:0] buf_q, buf_d;
  logic            accept;

  assign fire     = pend_q & out_ready;
  // Ready as soon as every owed channel is done or finishing now, so a new word can load with no bubble.
  assign in_ready = ((pend_q & ~fire) == '0);
  assign accept   = in_valid & in_ready;

`ifdef BCAST_FORK_MASK_EN
  assign dest = dst_mask;
`else
  assign dest = '1;
`endif

  always_comb begin
    pend_d = pend_q & ~fire;
    buf_d  = buf_q;
    if (accept) begin
      pend_d = dest;
      buf_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pend_q <= '0;
      buf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      buf_q  <= buf_d;
    end
  end

  assign out_valid = pend_q;
  assign out_data  = {OUT{buf_q}};
  assign busy      = |pend_q;

endmodule

// File: tb/tb_bcast_fork.sv
// tb/tb_bcast_fork.sv - scoreboard bench for bcast_fork: directed handshake scenarios plus random traffic.
module tb_bcast_fork;
  localparam int OUT  = 4;
  localparam int DATA = 16;

  logic                     clk;
  logic                     reset_;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA-1:0]          in_data;
  logic [OUT-1:0]           out_valid;
  logic [OUT-1:0]           out_ready;
  logic [OUT-1:0][DATA-1:0] out_data;
  logic                     busy;
`ifdef BCAST_FORK_MASK_EN
  logic [OUT-1:0]           dst_mask;
`endif

  int errors = 0;
  int checks = 0;

  logic [OUT-1:0]  m_pend;
  logic [DATA-1:0] m_buf;
  int              n_acc = 0;
  logic [DATA-1:0] sb_q [OUT][$];

  bcast_fork #(.OUT(OUT), .DATA(DATA)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef BCAST_FORK_MASK_EN
    .dst_mask  (dst_mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT-1:0] m_dest();
`ifdef BCAST_FORK_MASK_EN
    return dst_mask;
`else
    return '1;
`endif
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_buf  = '0;
    for (int k = 0; k < OUT; k++) sb_q[k].delete();
  endtask

  // Advance the reference model with the inputs currently applied, then cross one rising edge.
  task automatic clk_step();
    logic [OUT-1:0] f;
    logic [OUT-1:0] d;
    f = m_pend & out_ready;
    if (in_valid && ((m_pend & ~f) == '0)) begin
      d      = m_dest();
      m_pend = d;
      m_buf  = in_data;
      n_acc++;
      for (int k = 0; k < OUT; k++) if (d[k]) sb_q[k].push_back(in_data);
    end else begin
      m_pend = m_pend & ~f;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;
`ifdef BCAST_FORK_MASK_EN
    dst_mask = '1;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_ = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    in_valid = 1'b1; in_data = 16'h7777;
    clk_step();
    in_valid = 1'b0; out_ready = 4'b0101;
    @(negedge clk);
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL hold_out_valid got=%b exp=1111", out_valid); end
    clk_step();
    out_ready = 4'b0000;
    @(negedge clk);
    checks++; if (out_valid !== 4'b1010) begin errors++; $display("FAIL pre_reset_pend got=%b exp=1010", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
    reset_ = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL async_reset_out_valid got=%b exp=0000", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1 reset_ = 1'b1;
    out_ready = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL post_reset_no_delivery cyc=%0d got=%b exp=0000", c, out_valid); end
      clk_step();
    end
    out_ready = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [DATA-1:0] words [8];
    words[0] = 16'hA5A5; words[1] = 16'h5A5A; words[2] = 16'h0001; words[3] = 16'hFFFF;
    words[4] = 16'h8000; words[5] = 16'h1357; words[6] = 16'h2468; words[7] = 16'h0000;
    out_ready = 4'b1111;
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8);
      in_data  = (i < 8) ? words[i] : 16'h0000;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready i=%0d got=%b exp=1", i, in_ready); end
      checks++; if (out_valid !== ((i > 0) ? 4'b1111 : 4'b0000)) begin errors++; $display("FAIL b2b_out_valid i=%0d got=%b", i, out_valid); end
      if (i > 0) begin
        for (int k = 0; k < OUT; k++) begin
          checks++; if (out_data[k] !== words[i-1]) begin errors++; $display("FAIL b2b_data i=%0d ch=%0d got=%h exp=%h", i, k, out_data[k], words[i-1]); end
        end
      end
      clk_step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drain got=%b exp=0000", out_valid); end
    out_ready = 4'b0000;
  endtask

  task automatic test_partial();
    logic [OUT-1:0] rdy_seq [3];
    logic [OUT-1:0] vld_seq [3];
    logic           ir_seq  [3];
    rdy_seq[0] = 4'b0001; rdy_seq[1] = 4'b0100; rdy_seq[2] = 4'b1010;
    vld_seq[0] = 4'b1111; vld_seq[1] = 4'b1110; vld_seq[2] = 4'b1010;
    ir_seq[0]  = 1'b0;    ir_seq[1]  = 1'b0;    ir_seq[2]  = 1'b1;
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 4'b0000;
    clk_step();
    in_valid = 1'b0; in_data = 16'hDEAD;
    for (int s = 0; s < 3; s++) begin
      out_ready = rdy_seq[s];
      @(negedge clk);
      checks++; if (out_valid !== vld_seq[s]) begin errors++; $display("FAIL partial_valid s=%0d got=%b exp=%b", s, out_valid, vld_seq[s]); end
      checks++; if (in_ready !== ir_seq[s]) begin errors++; $display("FAIL partial_in_ready s=%0d got=%b exp=%b", s, in_ready, ir_seq[s]); end
      checks++; if (out_data[3] !== 16'h1234) begin errors++; $display("FAIL partial_data s=%0d got=%h exp=1234", s, out_data[3]); end
      clk_step();
    end
    out_ready = 4'b1111;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL partial_no_refire got=%b exp=0000", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got=%b exp=0", busy); end
    clk_step();
    out_ready = 4'b0000;
  endtask

  task automatic test_no_bubble();
    in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 4'b0000;
    clk_step();
    in_valid = 1'b0; out_ready = 4'b0111;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nb_in_ready_busy got=%b exp=0", in_ready); end
    clk_step();
    in_valid = 1'b1; in_data = 16'hCAFE; out_ready = 4'b1000;
    @(negedge clk);
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL nb_last_valid got=%b exp=1000", out_valid); end
    checks++; if (out_data[3] !== 16'hBEEF) begin errors++; $display("FAIL nb_last_data got=%h exp=beef", out_data[3]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nb_in_ready got=%b exp=1", in_ready); end
    clk_step();
    in_valid = 1'b0; out_ready = 4'b0000;
    @(negedge clk);
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL nb_reload_valid got=%b exp=1111", out_valid); end
    for (int k = 0; k < OUT; k++) begin
      checks++; if (out_data[k] !== 16'hCAFE) begin errors++; $display("FAIL nb_reload_data ch=%0d got=%h exp=cafe", k, out_data[k]); end
    end
    out_ready = 4'b1111;
    clk_step();
    out_ready = 4'b0000;
  endtask

`ifdef BCAST_FORK_MASK_EN
  task automatic test_mask();
    in_valid = 1'b1; in_data = 16'h0F0F; dst_mask = 4'b0110; out_ready = 4'b0000;
    clk_step();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0110) begin errors++; $display("FAIL mask_valid got=%b exp=0110", out_valid); end
    checks++; if (out_data[2] !== 16'h0F0F) begin errors++; $display("FAIL mask_data got=%h exp=0f0f", out_data[2]); end
    out_ready = 4'b1111;
    clk_step();
    in_valid = 1'b1; in_data = 16'hDEAD; dst_mask = 4'b0000;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mask_zero_accept got=%b exp=1", in_ready); end
    clk_step();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mask_zero_valid got=%b exp=0000", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mask_zero_in_ready got=%b exp=1", in_ready); end
    dst_mask = '1; out_ready = 4'b0000;
    clk_step();
  endtask
`endif

  task automatic test_random();
    int             cycles;
    int             start;
    logic [OUT-1:0] f;
    logic           exp_rdy;
    logic [DATA-1:0] exp_d;
    cycles = 0;
    start  = n_acc;
    for (int k = 0; k < OUT; k++) sb_q[k].delete();
    while (((n_acc - start) < 1000 || m_pend != '0) && cycles < 20000) begin
      in_valid  = ((n_acc - start) < 1000) ? 1'($urandom) : 1'b0;
      in_data   = DATA'($urandom);
      out_ready = OUT'($urandom);
`ifdef BCAST_FORK_MASK_EN
      dst_mask  = OUT'($urandom);
`endif
      @(negedge clk);
      f = m_pend & out_ready;
      exp_rdy = ((m_pend & ~f) == '0);
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cycles, in_ready, exp_rdy); end
      checks++; if (out_valid !== m_pend) begin errors++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cycles, out_valid, m_pend); end
      for (int k = 0; k < OUT; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          checks++;
          if (sb_q[k].size() == 0) begin
            errors++; $display("FAIL rand_extra_word ch=%0d cyc=%0d got=%h exp=none", k, cycles, out_data[k]);
          end else begin
            exp_d = sb_q[k].pop_front();
            if (out_data[k] !== exp_d) begin errors++; $display("FAIL rand_data ch=%0d cyc=%0d got=%h exp=%h", k, cycles, out_data[k], exp_d); end
          end
        end
      end
      clk_step();
      cycles++;
    end
    in_valid = 1'b0; out_ready = 4'b0000;
    checks++; if ((n_acc - start) < 1000) begin errors++; $display("FAIL rand_timeout got=%0d exp=1000", n_acc - start); end
    for (int k = 0; k < OUT; k++) begin
      checks++; if (sb_q[k].size() != 0) begin errors++; $display("FAIL rand_dropped ch=%0d got=%0d exp=0", k, sb_q[k].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial();
    test_no_bubble();
`ifdef BCAST_FORK_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcast_fork.md
Name: bcast_fork

Overview:
- Parameterized one-to-many broadcast fork. It is the fan-out counterpart of the team's N-to-1 data reduction block.
- Takes one DATA-wide word on a valid/ready input and delivers a copy to each of OUT consumers, each on its own valid/ready channel.
- Holds the word in a single-entry buffer and tracks per-output acceptance, so consumers may accept on different cycles.
- Used to feed parallel lanes that later rejoin through the reduction tree.

Parameters:
- OUT, 4, number of output channels (>= 1).
- DATA, 16, width of data word in bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept upstream word this cycle.
- in_data  input  DATA  upstream word.
- out_valid  output  OUT  per-channel word valid.
- out_ready  input  OUT  per-channel consumer ready.
- out_data  output  [OUT-1:0][DATA-1:0]  per-channel word copy.
- busy  output  1  a word is held with at least one delivery outstanding.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low; clock port clk, reset port reset_.
- State:
  - buf_data[DATA-1:0], the held word.
  - pend[OUT-1:0], outputs still owed the held word.
  - Logical states: IDLE (pend == 0) and HOLD (pend != 0). No other encoding is needed.
- Reset (reset_ low, async): pend = 0, buf_data = 0. Therefore out_valid = 0, busy = 0, in_ready = 1. Any in-flight word is discarded with no partial delivery afterwards.
- Outputs:
  - out_valid[i] = pend[i].
  - out_data[i] = buf_data for every i; the copy is stable while pend[i] = 1.
  - busy = |pend.
- Per-channel handshake:
  - fire[i] = out_valid[i] & out_ready[i].
  - out_ready[i] while out_valid[i] = 0 is ignored.
- Completion: last = ((pend & ~fire) == 0). This is true in IDLE, or in HOLD when every remaining channel fires this cycle.
- in_ready = last. It is combinational from out_ready; this path is accepted.
- Accept = in_valid & in_ready. On accept at clock edge:
  - buf_data <= in_data.
  - pend <= dest, where dest = all ones by default (see Optional Feature).
- Otherwise: pend <= pend & ~fire, and buf_data holds.
- Latency: 1 cycle from accept to out_valid asserting.
- Throughput: 1 word/cycle when all consumers hold ready continuously (back-to-back accept in the completing cycle).
- Ordering: words delivered in accept order. Each channel sees each destined word exactly once.
- Boundary conditions:
  - Simultaneous last fire and new accept: the new word loads, pend reloads; no bubble.
  - Channel fires earlier than others: its out_valid drops next cycle and stays low until the next word loads, even if out_ready stays high.
  - in_valid low in IDLE: nothing changes.
  - OUT = 1: degenerates to a one-entry pipeline register.
  - in_data is not required stable before accept. in_valid may drop without accept (no upstream obligation checked here).

Optional Feature:
- Macro: BCAST_FORK_MASK_EN.
- Defined:
  - Adds input port dst_mask[OUT-1:0], sampled with in_data on accept; dest = dst_mask.
  - Only masked-in channels assert out_valid.
  - dst_mask = 0 on accept: the word is consumed and dropped, pend stays 0, no out_valid asserts, in_ready remains 1 next cycle.
- Undefined: no dst_mask port; dest = all ones; every word goes to all OUT channels.

Test Plan:
- Reset then idle, OUT=4, DATA=16, reset_ low mid-hold with pend=4'b1010 -> pend cleared immediately; out_valid=0, busy=0, in_ready=1; no delivery after reset release.
- in_data=16'hA5A5 accepted, out_ready=4'b1111 held -> next cycle out_valid=4'b1111 and all out_data=16'hA5A5. The following word 16'h5A5A is accepted in that same cycle, giving 1 word/cycle over 8 back-to-back words.
- Word 16'h1234 held, out_ready sequence 4'b0001, 4'b0100, 4'b1010 -> out_valid goes 1111, 1110, 1010, then 0000. in_ready stays 0 until the third cycle, when it is 1. Each channel fires exactly once.
- Word 16'hBEEF held with 3 channels done, new word 16'hCAFE valid, last channel ready -> 16'hCAFE accepted the same cycle; next cycle out_valid=4'b1111 and out_data=16'hCAFE; no bubble.
- Random out_ready (50%) and random in_valid over 1000 words -> scoreboard per channel: each channel receives the exact accept-ordered sequence with no duplicates or drops.
- With BCAST_FORK_MASK_EN: dst_mask=4'b0110 with word 16'h0F0F -> only out_valid[1], out_valid[2] assert. dst_mask=4'b0000 -> word dropped, out_valid stays 0, in_ready=1 next cycle.
